motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pwm_driver.sv | 135 +++++++++++++
 tb/tb_motor_pwm_driver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: samples a signed duty command once per PWM period and
// drives one leg of the bridge, inserting all-off periods on direction reversal.
module motor_pwm_driver #(
  parameter int PWM_PERIOD   = 5000,
  parameter int MAX_DUTY     = 4000,
  parameter int DEAD_PERIODS = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [15:0] control_signal,
  output logic               in1,
  output logic               in2,
  output logic               dir,
  output logic               pwm_sync,
  output logic [12:0]        duty_active
);

  localparam int unsigned CW = ($clog2(PWM_PERIOD) > 13) ? $clog2(PWM_PERIOD) : 13;

  typedef enum logic [1:0] {COAST, FWD, REV, DEAD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dead_q, dead_d;
  logic [12:0]   duty_q, duty_d;
  logic          dir_q, dir_d;
  logic          in1_q, in1_d;
  logic          in2_q, in2_d;
  logic          sync_q;
  logic [16:0]   mag;
  logic [12:0]   cmd_duty;
  logic          cmd_pos, cmd_neg;
  logic          launch;
  logic          pulse_win;

  always_comb begin
    cnt_d    = (cnt_q == CW'(PWM_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    // 17-bit negation so that -32768 yields a magnitude of 32768
    mag      = control_signal[15] ? 17'(-{control_signal[15], control_signal})
                                  : {1'b0, control_signal};
    cmd_duty = (mag > 17'(MAX_DUTY)) ? 13'(MAX_DUTY) : mag[12:0];
    cmd_neg  = control_signal[15];
    cmd_pos  = !control_signal[15] && (control_signal != '0);

    state_d = state_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    dir_d   = dir_q;
    launch  = 1'b0;

    if (!enable) begin
      state_d = COAST;
      duty_d  = '0;
      dead_d  = '0;
    end else if (sync_q) begin
      case (state_q)
        COAST: launch = 1'b1;
        FWD: begin
          if (cmd_pos) duty_d = cmd_duty;
          else begin
            state_d = cmd_neg ? DEAD : COAST;
            duty_d  = '0;
            dead_d  = '0;
          end
        end
        REV: begin
          if (cmd_neg) duty_d = cmd_duty;
          else begin
            state_d = cmd_pos ? DEAD : COAST;
            duty_d  = '0;
            dead_d  = '0;
          end
        end
        DEAD: begin
          if (dead_q == 4'(DEAD_PERIODS - 1)) begin
            dead_d = '0;
            launch = 1'b1;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
      endcase

      if (launch) begin
        if (cmd_pos) begin
          state_d = FWD;
          dir_d   = 1'b1;
          duty_d  = cmd_duty;
        end else if (cmd_neg) begin
          state_d = REV;
          dir_d   = 1'b0;
          duty_d  = cmd_duty;
        end else begin
          state_d = COAST;
          duty_d  = '0;
        end
      end
    end

    // Legs are registered from next-state so the pulse covers counts 1..duty
    pulse_win = (cnt_d != '0) && (cnt_d <= CW'(duty_d));
    in1_d     = (state_d == FWD) && pulse_win;
    in2_d     = (state_d == REV) && pulse_win;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= COAST;
      duty_q  <= '0;
      dead_q  <= '0;
      dir_q   <= 1'b1;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      dir_q   <= dir_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sync_q  <= (cnt_d == '0);
    end
  end

  assign in1         = in1_q;
  assign in2         = in2_q;
  assign dir         = dir_q;
  assign pwm_sync    = sync_q;
  assign duty_active = duty_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed + random bench for motor_pwm_driver with a per-period scoreboard.
module tb_motor_pwm_driver;

  localparam int P  = 200;
  localparam int MD = 150;
  localparam int DP = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] control_signal = '0;
  logic               in1, in2, dir, pwm_sync;
  logic [12:0]        duty_active;

  int checks = 0;
  int errors = 0;

  typedef struct {int n1; int n2; int dir; int duty;} exp_t;
  exp_t sb[$];

  // Bench model state: 0 COAST, 1 FWD, 2 REV, 3 DEAD
  int m_state = 0;
  int m_dir   = 1;
  int m_duty  = 0;
  int m_dead  = 0;

  motor_pwm_driver #(
    .PWM_PERIOD  (P),
    .MAX_DUTY    (MD),
    .DEAD_PERIODS(DP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .control_signal(control_signal),
    .in1           (in1),
    .in2           (in2),
    .dir           (dir),
    .pwm_sync      (pwm_sync),
    .duty_active   (duty_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      assert (!(in1 === 1'b1 && in2 === 1'b1))
      else begin
        errors++;
        $error("FAIL overlap: in1=%b in2=%b, required not both 1", in1, in2);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int clamp_mag(input int c);
    int m;
    m = (c < 0) ? -c : c;
    return (m > MD) ? MD : m;
  endfunction

  task automatic model_launch(input int c);
    if (c > 0) begin
      m_state = 1; m_dir = 1; m_duty = clamp_mag(c);
    end else if (c < 0) begin
      m_state = 2; m_dir = 0; m_duty = clamp_mag(c);
    end else begin
      m_state = 0; m_duty = 0;
    end
  endtask

  task automatic model_sample(input int c, input bit e);
    if (!e) begin
      m_state = 0; m_duty = 0; m_dead = 0;
    end else begin
      case (m_state)
        0: model_launch(c);
        1: if (c > 0) m_duty = clamp_mag(c);
           else begin m_state = (c < 0) ? 3 : 0; m_duty = 0; m_dead = 0; end
        2: if (c < 0) m_duty = clamp_mag(c);
           else begin m_state = (c > 0) ? 3 : 0; m_duty = 0; m_dead = 0; end
        default: if (m_dead == DP - 1) begin m_dead = 0; model_launch(c); end
                 else m_dead++;
      endcase
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.n1   = (m_state == 1) ? m_duty : 0;
    e.n2   = (m_state == 2) ? m_duty : 0;
    e.dir  = m_dir;
    e.duty = (m_state == 1 || m_state == 2) ? m_duty : 0;
    return e;
  endfunction

  task automatic wait_sync(input string tag, output int hi);
    bit seen = 1'b0;
    hi = 0;
    for (int i = 0; i < 2 * P && !seen; i++) begin
      @(negedge clk);
      if (pwm_sync) seen = 1'b1;
      else hi += int'(in1) + int'(in2);
    end
    check(tag, int'(seen), 1);
  endtask

  // Called at the negedge of a sync cycle; drives the command sampled on the next edge
  task automatic step(input int c, input bit e, input bit mid, input int midc);
    exp_t ex;
    int   n1 = 0, n2 = 0, d_dir = 0, d_duty = 0;
    control_signal = 16'(c);
    enable         = e;
    model_sample(c, e);
    sb.push_back(model_expect());
    for (int i = 1; i <= P; i++) begin
      @(negedge clk);
      if (mid && i == P / 2) control_signal = 16'(midc);
      if (i == 1) begin
        d_dir  = int'(dir);
        d_duty = int'(duty_active);
      end
      n1 += int'(in1);
      n2 += int'(in2);
    end
    check("sync_period", int'(pwm_sync), 1);
    ex = sb.pop_front();
    check("in1_high", n1, ex.n1);
    check("in2_high", n2, ex.n2);
    check("dir", d_dir, ex.dir);
    check("duty_active", d_duty, ex.duty);
  endtask

  initial begin
    int hi;
    repeat (3) @(negedge clk);
    check("rst_in1", int'(in1), 0);
    check("rst_in2", int'(in2), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_duty", int'(duty_active), 0);
    check("rst_sync", int'(pwm_sync), 0);

    control_signal = 16'sd100;
    enable  = 1'b1;
    reset_n = 1'b1;
    wait_sync("first_sync", hi);
    check("pre_sync_idle", hi, 0);

    step(100, 1, 0, 0);
    step(100, 1, 1, -120);
    step(-120, 1, 0, 0);
    step(-120, 1, 0, 0);
    step(-120, 1, 0, 0);
    step(-120, 1, 1, 90);

    for (int k = 0; k < 4; k++) step(32767, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(-32768, 1, 0, 0);

    step(0, 1, 0, 0);
    step(-50, 1, 0, 0);
    step(0, 1, 0, 0);
    step(80, 0, 0, 0);
    step(80, 1, 0, 0);

    control_signal = 16'sd100;
    enable = 1'b1;
    model_sample(100, 1);
    repeat (10) @(negedge clk);
    check("en_pre_in1", int'(in1), 1);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_in1", int'(in1), 0);
    check("en_drop_duty", int'(duty_active), 0);
    m_state = 0; m_duty = 0; m_dead = 0;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    hi = 0;
    for (int i = 32; i <= P; i++) begin
      @(negedge clk);
      hi += int'(in1) + int'(in2);
    end
    check("en_rise_idle", hi, 0);
    check("en_rise_sync", int'(pwm_sync), 1);
    step(100, 1, 0, 0);

    step(MD, 1, 0, 0);
    step(MD + 1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(MD, 1, 0, 0);

    control_signal = 16'(MD);
    enable = 1'b1;
    model_sample(MD, 1);
    repeat (10) @(negedge clk);
    check("rst_mid_pre", int'(in1), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_in1", int'(in1), 0);
    check("rst_mid_in2", int'(in2), 0);
    check("rst_mid_dir", int'(dir), 1);
    check("rst_mid_duty", int'(duty_active), 0);
    m_state = 0; m_dir = 1; m_duty = 0; m_dead = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_sync("rst_resync", hi);
    check("rst_resync_idle", hi, 0);

    for (int k = 0; k < 24; k++) begin
      int c;
      c = int'($urandom_range(0, 400)) - 200;
      if ($urandom_range(0, 7) == 0) c = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      step(c, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 400)) - 200);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
